// File: rtl/sprite_pkg.sv
// Shared sprite geometry defaults and writer state encoding, common to the
// sprite readers and the image writer.
package sprite_pkg;

  localparam int unsigned SpriteW = 50;
  localparam int unsigned SpriteH = 50;
  localparam int unsigned AddrW   = 13;
  localparam int unsigned DataW   = 9;
  localparam int unsigned CoordW  = 6;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StFinish
  } writerState_t;

endpackage

// File: rtl/raster_addr_gen.sv
// Raster-order address walker over a rectangle inside the sprite image.
// Holds col/row/rowBase so the streaming path needs only adders.
module raster_addr_gen import sprite_pkg::*; #(
  parameter int unsigned SPRITE_W = SpriteW,
  parameter int unsigned ADDR_W   = AddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [CoordW-1:0] xStart,
  input  logic [CoordW-1:0] yStart,
  input  logic [CoordW-1:0] rectW,
  input  logic [CoordW-1:0] rectH,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [CoordW-1:0] colQ;
  logic [CoordW-1:0] rowQ;
  logic [CoordW-1:0] rectWQ;
  logic [CoordW-1:0] rectHQ;
  logic [ADDR_W-1:0] rowBaseQ;
  logic              rowEnd;

  assign rowEnd = (colQ == rectWQ - CoordW'(1));
  assign last   = rowEnd && (rowQ == rectHQ - CoordW'(1));
  assign addr   = rowBaseQ + ADDR_W'(colQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      colQ     <= '0;
      rowQ     <= '0;
      rectWQ   <= '0;
      rectHQ   <= '0;
      rowBaseQ <= '0;
    end else if (load) begin
      colQ     <= '0;
      rowQ     <= '0;
      rectWQ   <= rectW;
      rectHQ   <= rectH;
      // Constant-multiplier product, evaluated once per transfer.
      rowBaseQ <= ADDR_W'(yStart) * ADDR_W'(SPRITE_W) + ADDR_W'(xStart);
    end else if (advance) begin
      if (rowEnd) begin
        colQ     <= '0;
        rowQ     <= rowQ + CoordW'(1);
        rowBaseQ <= rowBaseQ + ADDR_W'(SPRITE_W);
      end else begin
        colQ <= colQ + CoordW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_image_writer.sv
// Streams a raster-ordered pixel rectangle into the sprite image RAM write
// port, with a bounds check on the requested rectangle.
module sprite_image_writer import sprite_pkg::*; #(
  parameter int unsigned SPRITE_W = SpriteW,
  parameter int unsigned SPRITE_H = SpriteH,
  parameter int unsigned ADDR_W   = AddrW,
  parameter int unsigned DATA_W   = DataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CoordW-1:0] xStart,
  input  logic [CoordW-1:0] yStart,
  input  logic [CoordW-1:0] rectW,
  input  logic [CoordW-1:0] rectH,
  input  logic [DATA_W-1:0] pixelIn,
  input  logic              pixelValid,
  output logic              pixelReady,
  output logic              wEn,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dataIn,
  output logic              busy,
  output logic              done,
  output logic              error
);

  writerState_t      stateQ, stateD;
  logic              wEnQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] dataQ;
  logic              errorQ, errorD;
  logic              load;
  logic              handshake;
  logic              fits;
  logic              empty;
  logic [CoordW:0]   xSum;
  logic [CoordW:0]   ySum;
  logic [ADDR_W-1:0] genAddr;
  logic              genLast;

  // One extra bit so the right/bottom edge sums cannot overflow.
  assign xSum  = {1'b0, xStart} + {1'b0, rectW};
  assign ySum  = {1'b0, yStart} + {1'b0, rectH};
  assign fits  = (xSum <= (CoordW + 1)'(SPRITE_W)) && (ySum <= (CoordW + 1)'(SPRITE_H));
  assign empty = (rectW == '0) || (rectH == '0);

  assign pixelReady = (stateQ == StWrite);
  assign handshake  = pixelReady && pixelValid;
  assign busy       = (stateQ != StIdle);
  assign done       = (stateQ == StFinish);
  assign wEn        = wEnQ;
  assign addr       = addrQ;
  assign dataIn     = dataQ;
  assign error      = errorQ;

  always_comb begin
    stateD = stateQ;
    load   = 1'b0;
    errorD = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          if (!fits) begin
            errorD = 1'b1;
          end else if (empty) begin
            stateD = StFinish;
          end else begin
            load   = 1'b1;
            stateD = StWrite;
          end
        end
      end
      StWrite: begin
        if (handshake && genLast) stateD = StFinish;
      end
      StFinish: stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= StIdle;
      wEnQ   <= 1'b0;
      addrQ  <= '0;
      dataQ  <= '0;
      errorQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      wEnQ   <= handshake;
      errorQ <= errorD;
      if (handshake) begin
        addrQ <= genAddr;
        dataQ <= pixelIn;
      end
    end
  end

  raster_addr_gen #(
    .SPRITE_W(SPRITE_W),
    .ADDR_W  (ADDR_W)
  ) u_addrGen (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .advance(handshake),
    .xStart (xStart),
    .yStart (yStart),
    .rectW  (rectW),
    .rectH  (rectH),
    .addr   (genAddr),
    .last   (genLast)
  );

endmodule

// File: tb/tb_sprite_image_writer.sv
// Bench for sprite_image_writer: cycle model derived from the transfer rules,
// plus literal address/timing expectations for directed cases.
module tb_sprite_image_writer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [5:0]        xStart = '0, yStart = '0, rectW = '0, rectH = '0;
  logic [DATA_W-1:0] pixelIn = '0;
  logic              pixelValid = 1'b0;
  logic              pixelReady, wEn, busy, done, error;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataIn;

  sprite_image_writer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .xStart    (xStart),
    .yStart    (yStart),
    .rectW     (rectW),
    .rectH     (rectH),
    .pixelIn   (pixelIn),
    .pixelValid(pixelValid),
    .pixelReady(pixelReady),
    .wEn       (wEn),
    .addr      (addr),
    .dataIn    (dataIn),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  bit checkEn = 1'b0;
  int logA[$];
  int logD[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pixel k of a WxH rectangle lands at (y0+k/W)*50 + x0+k%W.
  typedef enum {MIdle, MWrite, MFinish} mState_t;
  mState_t m = MIdle;
  int  k = 0, rx = 0, ry = 0, rw = 1, rh = 1;
  bit  eWEn = 0, eErr = 0;
  int  eAddr = 0, eData = 0;

  always @(posedge clk) begin
    eWEn = 0;
    eErr = 0;
    if (reset) begin
      m = MIdle;
      eAddr = 0;
      eData = 0;
    end else begin
      case (m)
        MIdle: if (start) begin
          if (int'(xStart) + int'(rectW) > 50 || int'(yStart) + int'(rectH) > 50) eErr = 1;
          else if (rectW == 0 || rectH == 0) m = MFinish;
          else begin
            m = MWrite; k = 0;
            rx = xStart; ry = yStart; rw = rectW; rh = rectH;
          end
        end
        MWrite: if (pixelValid) begin
          eWEn  = 1;
          eAddr = (ry + k / rw) * 50 + rx + k % rw;
          eData = int'(pixelIn);
          k++;
          if (k == rw * rh) m = MFinish;
        end
        MFinish: m = MIdle;
        default: m = MIdle;
      endcase
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      chk("pixelReady", pixelReady, int'(m == MWrite));
      chk("busy", busy, int'(m != MIdle));
      chk("done", done, int'(m == MFinish));
      chk("error", error, eErr);
      chk("wEn", wEn, eWEn);
      chk("addr", addr, eAddr);
      chk("dataIn", dataIn, eData);
    end
    if (wEn) begin
      logA.push_back(int'(addr));
      logD.push_back(int'(dataIn));
    end
  end

  int startCyc;

  task automatic doStart(input int x, input int y, input int w, input int h);
    start = 1; xStart = 6'(x); yStart = 6'(y); rectW = 6'(w); rectH = 6'(h);
    startCyc = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic sendPixels(input int n, input int base, input bit stall, input int startAt);
    int i = 0;
    int budget = 0;
    bit hs;
    bit pulsed = 0;
    while (i < n) begin
      pixelIn = DATA_W'((base + i) % 512);
      pixelValid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i == startAt && !pulsed) begin
        start = 1; xStart = 6'd48; yStart = 6'd0; rectW = 6'd3; rectH = 6'd1;
        pulsed = 1;
      end else start = 0;
      @(negedge clk);
      hs = pixelValid && pixelReady;
      @(posedge clk); #1;
      if (hs) i++;
      budget++;
      if (budget > 20 * n + 50) begin
        chk("send_timeout", i, n);
        break;
      end
    end
    pixelValid = 0;
    start = 0;
  endtask

  task automatic waitIdle(output int at);
    int b = 0;
    at = -1;
    while (b < 5000) begin
      @(negedge clk);
      if (!busy) begin
        at = cyc;
        break;
      end
      b++;
    end
    if (at < 0) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic checkLog(input string nm, input int ea[$], input int base);
    chk({nm, "_count"}, logA.size(), ea.size());
    for (int i = 0; i < ea.size() && i < logA.size(); i++) begin
      chk({nm, "_addr"}, logA[i], ea[i]);
      chk({nm, "_data"}, logD[i], base + i);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, bad;
    int ea[$];
    @(posedge clk); #1;
    checkEn = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wEn", wEn, 0);
    chk("rst_addr", addr, 0);
    chk("rst_ready", pixelReady, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    // Full sprite, no stalls.
    logA.delete(); logD.delete();
    doStart(0, 0, 50, 50);
    sendPixels(2500, 0, 0, -1);
    waitIdle(at);
    chk("full_cycles", at - startCyc, 2502);
    chk("full_count", logA.size(), 2500);
    bad = 0;
    for (int i = 0; i < logA.size(); i++)
      if (logA[i] != i || logD[i] != i % 512) bad++;
    chk("full_order", bad, 0);

    // Sub-rectangle.
    logA.delete(); logD.delete();
    doStart(10, 20, 3, 2);
    @(negedge clk);
    chk("sub_ready_s1", pixelReady, 1);
    @(posedge clk); #1;
    sendPixels(6, 1, 0, -1);
    waitIdle(at);
    ea = '{1010, 1011, 1012, 1060, 1061, 1062};
    checkLog("sub", ea, 1);

    // Same rectangle with random stalls.
    logA.delete(); logD.delete();
    doStart(10, 20, 3, 2);
    sendPixels(6, 1, 1, -1);
    waitIdle(at);
    checkLog("stall", ea, 1);

    // Clipped rectangle.
    logA.delete(); logD.delete();
    doStart(48, 0, 3, 1);
    @(negedge clk);
    chk("clip_error", error, 1);
    chk("clip_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("clip_writes", logA.size(), 0);

    // Empty rectangle.
    doStart(0, 0, 0, 5);
    @(negedge clk);
    chk("empty_done", done, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("empty_writes", logA.size(), 0);

    // Reset mid-transfer, then a fresh transfer.
    doStart(0, 0, 10, 10);
    sendPixels(3, 7, 0, -1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mid_rst_wEn", wEn, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", pixelReady, 0);
    @(posedge clk); #1;
    logA.delete(); logD.delete();
    doStart(0, 0, 2, 2);
    sendPixels(4, 20, 0, -1);
    waitIdle(at);
    ea = '{0, 1, 50, 51};
    checkLog("fresh", ea, 20);

    // Start pulsed while writing is ignored.
    logA.delete(); logD.delete();
    doStart(5, 5, 4, 1);
    sendPixels(4, 40, 0, 2);
    waitIdle(at);
    ea = '{255, 256, 257, 258};
    checkLog("busy_start", ea, 40);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sprite_image_writer.md
# sprite_image_writer

Loads palette-index pixels into a sprite image RAM, the write-side counterpart of the per-pixel sprite readers that map screen (x, y) to image address `x + SPRITE_W*y`. A host pulses `start` with a target rectangle inside the sprite. The block then accepts a raster-ordered pixel stream over a valid/ready handshake and drives the RAM write port (`wEn`, `addr`, `dataIn`). It sits between an asset loader (UART or procedural generator) and the sprite image RAM, so the game can replace or patch sprite art at run time.

## Interface
- `SPRITE_W`, default 50: sprite width in pixels.
- `SPRITE_H`, default 50: sprite height in pixels.
- `ADDR_W`, default 13: image address width, $clog2(SPRITE_W*SPRITE_H)+1.
- `DATA_W`, default 9: palette index width, $clog2(256)+1.
- `clk`, in, 1: system clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle request. Sampled only in IDLE.
- `xStart`, in, 6: rectangle left column. Latched on accepted `start`.
- `yStart`, in, 6: rectangle top row. Latched on accepted `start`.
- `rectW`, in, 6: rectangle width. Latched on accepted `start`.
- `rectH`, in, 6: rectangle height. Latched on accepted `start`.
- `pixelIn`, in, DATA_W: palette index of the current pixel.
- `pixelValid`, in, 1: `pixelIn` is valid.
- `pixelReady`, out, 1: the block accepts a pixel this cycle.
- `wEn`, out, 1: RAM write enable.
- `addr`, out, ADDR_W: RAM write address.
- `dataIn`, out, DATA_W: RAM write data.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse when a transfer completes.
- `error`, out, 1: one-cycle pulse when `start` is rejected.

## Operation
- States are IDLE, WRITE and FINISH.
- **IDLE**
  - On `start`, check `xStart+rectW <= SPRITE_W` and `yStart+rectH <= SPRITE_H`. Use 7-bit sums so nothing overflows.
  - If either check fails, pulse `error` next cycle and stay in IDLE.
  - If `rectW==0` or `rectH==0`, go to FINISH with no writes.
  - Otherwise latch the rectangle. Set `col=0`, `row=0`, `rowBase=yStart*SPRITE_W+xStart`, then go to WRITE.
- **WRITE**
  - `pixelReady=1`. A handshake is `pixelValid & pixelReady`.
  - On each handshake, register `wEn=1`, `addr=rowBase+col`, `dataIn=pixelIn`.
  - Then advance: `col+1`. When `col==rectW-1`: set `col=0`, `row+1`, `rowBase+=SPRITE_W`.
  - The handshake with `col==rectW-1` and `row==rectH-1` goes to FINISH.
  - If `pixelValid` is low, no write happens and the counters hold. Stalls of any length are legal.
- **FINISH**
  - `pixelReady=0`, `done=1` for exactly one cycle, then return to IDLE.
- Address arithmetic:
  - No multiplier in the streaming path. `yStart*SPRITE_W` is computed once at start; it is constant-multiplier logic and may be registered.
  - `rowBase` and `addr` are ADDR_W wide.
  - Maximum address is `SPRITE_W*SPRITE_H-1`, so addresses never wrap.
- `start` outside IDLE is ignored: no error and no effect.
- Reset mid-transfer:
  - Abandons the transfer and returns to IDLE.
  - Already-written RAM words stay as written.
  - No `done` pulse is produced.

## Timing
- Reset values: `pixelReady=0`, `wEn=0`, `addr=0`, `dataIn=0`, `busy=0`, `done=0`, `error=0`. State is IDLE; counters are 0.
- Cycle of accepted `start` is cycle S.
  - State is WRITE at S+1 (`pixelReady=1`, `busy=1`).
  - For an empty rectangle, state is FINISH at S+1.
- A handshake in cycle N gives `wEn=1` with matching `addr`/`dataIn` in cycle N+1. `wEn` is low in all other cycles.
- The final handshake at cycle L gives FINISH at L+1, so `done` and the last `wEn` are high together at L+1. The state is IDLE at L+2, and a new `start` is accepted at L+2.
- Zero-stall throughput is one pixel per cycle. A W×H transfer takes W·H+2 cycles from `start` to IDLE.
- `pixelReady` is a registered state decode. It has no combinational path from `pixelValid`.

## Structure
- The shared package `sprite_pkg` holds:
  - `SPRITE_W`, `SPRITE_H`, `ADDR_W` and `DATA_W` defaults, shared with the sprite readers.
  - The state enum.
- Sub-module `raster_addr_gen` holds `col`/`row`/`rowBase`. Its inputs are `load`, `advance`, the rectangle and `SPRITE_W`. Its outputs are `addr` and `last`.
- The top holds the FSM, the clip check and the output registers.
- The RAM itself is external, written via the RAM's `wEn` port.

## Test plan
- Full sprite: start (0,0,50,50), stream 2500 pixels with no stalls.
  - Writes go to addresses 0..2499 in order, `dataIn` matches each pixel.
  - `done` pulses with the final write, 2502 cycles total.
- Sub-rectangle: start (10,20,3,2), pixels 1..6.
  - Writes are addr 1010/1011/1012/1060/1061/1062 with data 1..6.
- Stalls: same 3×2 rectangle with `pixelValid` toggling randomly.
  - Identical write sequence, and no `wEn` without a prior handshake.
- Clipping: start (48,0,3,1) gives an `error` pulse, no writes, `busy` stays 0.
  - Start (0,0,0,5) gives a `done` pulse at S+1 and zero writes.
- Reset mid-operation: assert `reset` after 3 pixels of a 10×10 transfer.
  - Outputs return to their reset values the next cycle, with no `done`.
  - A fresh start then runs normally.
- Busy start: pulse `start` during WRITE.
  - It is ignored, with no `error` and no change to the address sequence.
